// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two combinational read ports, two write
// ports (port 1 wins on address collision), optional hardwired-zero register 0,
// and a post-reset sweep that zeroes every entry before raising ready.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] rd0,
  input  logic [DATA_WIDTH-1:0] write_data0,
  input  logic                  reg_write_en0,
  input  logic [ADDR_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] write_data1,
  input  logic                  reg_write_en1,
  output logic                  ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_ok0, wr_ok1;
  logic [ADDR_WIDTH-1:0] rs    [2];
  logic [DATA_WIDTH-1:0] rdata [2];

  // State register and clear pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: walk the pointer through every entry, leave CLEAR after the last one.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == StClear) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = StReady;
      end
    end
  end

  // Outputs decoded from state; a write is valid only when ready and not aimed at a hardwired zero.
  always_comb begin
    ready  = (state_q == StReady);
    wr_ok0 = reg_write_en0 && ready && !((ZERO_REG != 0) && (rd0 == '0));
    wr_ok1 = reg_write_en1 && ready && !((ZERO_REG != 0) && (rd1 == '0));
  end

  // Array update: sweep zeroes one entry per edge; in READY port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (wr_ok0) mem_q[rd0] <= write_data0;
        if (wr_ok1) mem_q[rd1] <= write_data1;
      end
    end
  end

  assign rs[0] = rs1;
  assign rs[1] = rs2;

  // Read ports: array data, optionally forwarded from this cycle's writes, forced to 0 while
  // clearing or when reading the hardwired zero register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem_q[rs[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok0 && (rd0 == rs[p])) rdata[p] = write_data0;
      if (wr_ok1 && (rd1 == rs[p])) rdata[p] = write_data1;
`endif
      if (!ready || ((ZERO_REG != 0) && (rs[p] == '0))) rdata[p] = '0;
    end
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at default parameters. A behavioural model tracks
// ready (edge count since reset) and register contents; a compare process checks every
// cycle, and directed steps add literal expectations.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd0, rd1;
  logic [31:0] read_data1, read_data2, write_data0, write_data1;
  logic        reg_write_en0, reg_write_en1, ready;

  int tests;
  int fails;
  bit started;

  regfile_mp dut (
    .clk           (clk),
    .rst           (rst),
    .rs1           (rs1),
    .rs2           (rs2),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .rd0           (rd0),
    .write_data0   (write_data0),
    .reg_write_en0 (reg_write_en0),
    .rd1           (rd1),
    .write_data1   (write_data1),
    .reg_write_en1 (reg_write_en1),
    .ready         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ready once 32 non-reset edges have elapsed; at that point every entry is zero.
  int unsigned sweep;
  bit          m_ready;
  logic [31:0] m_mem [32];

  initial begin
    sweep   = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 32; k++) m_mem[k] = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      sweep   <= 0;
      m_ready <= 1'b0;
    end else if (!m_ready) begin
      if (sweep == 31) begin
        m_ready <= 1'b1;
        sweep   <= 0;
        for (int k = 0; k < 32; k++) m_mem[k] <= '0;
      end else begin
        sweep <= sweep + 1;
      end
    end else begin
      if (reg_write_en0 && rd0 != 5'd0) m_mem[rd0] <= write_data0;
      if (reg_write_en1 && rd1 != 5'd0) m_mem[rd1] <= write_data1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (!m_ready || a == 5'd0) return 32'h0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (reg_write_en0 && rd0 == a) v = write_data0;
    if (reg_write_en1 && rd1 == a) v = write_data1;
`endif
    return v;
  endfunction

  // Every-cycle comparison against the model, sampled mid-period.
  always @(negedge clk) begin
    if (started) begin
      chk("model_ready", {31'd0, ready}, {31'd0, m_ready});
      chk("model_rd1", read_data1, exp_read(rs1));
      chk("model_rd2", read_data2, exp_read(rs2));
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    reg_write_en0 = 1'b0;
    reg_write_en1 = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    started = 1'b0;
    rst = 1'b1;
    rs1 = '0; rs2 = '0; rd0 = '0; rd1 = '0;
    write_data0 = '0; write_data1 = '0;
    reg_write_en0 = 1'b0; reg_write_en1 = 1'b0;

    // Two reset cycles.
    edge_step();
    started = 1'b1;
    edge_step();
    #1 chk("reset_ready", {31'd0, ready}, 32'd0);

    // Clear sweep, with writes to register 3 attempted on both ports throughout.
    rst = 1'b0;
    rs1 = 5'd7; rs2 = 5'd3;
    rd0 = 5'd3; rd1 = 5'd3;
    write_data0 = 32'hCAFEBABE; write_data1 = 32'hCAFEBABE;
    reg_write_en0 = 1'b1; reg_write_en1 = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      edge_step();
      chk("sweep_ready", {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i < 32) chk("sweep_rd1_r7", read_data1, 32'h0);
      if (i == 32) idle_writes();
    end
    #1 chk("clear_blocks_r3", read_data2, 32'h0);

    // Reset from READY, then reset again mid-sweep.
    rst = 1'b1;
    edge_step();
    chk("ready_falls", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) edge_step();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      edge_step();
      chk("resweep_ready", {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end

    // Basic write/read through port 0; not visible before the edge without bypass.
    rd0 = 5'd1; write_data0 = 32'hDEADBEEF; reg_write_en0 = 1'b1; rs1 = 5'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("pre_edge_r1", read_data1, 32'hDEADBEEF);
`else
    chk("pre_edge_r1", read_data1, 32'h0);
`endif
    edge_step();
    idle_writes();
    #1 chk("write_r1", read_data1, 32'hDEADBEEF);

    // Write to register 0 on port 1 is dropped; port 0 to register 2 still lands.
    rd1 = 5'd0; write_data1 = 32'h0BADC0DE; reg_write_en1 = 1'b1; rs2 = 5'd0;
    rd0 = 5'd2; write_data0 = 32'h00C0FFEE; reg_write_en0 = 1'b1;
    #1 chk("zero_bypass_r0", read_data2, 32'h0);
    edge_step();
    idle_writes();
    #1 chk("zero_r0", read_data2, 32'h0);
    rs1 = 5'd2;
    #1 chk("other_port_r2", read_data1, 32'h00C0FFEE);

    // Collision on register 4: port 1 wins.
    rd0 = 5'd4; rd1 = 5'd4;
    write_data0 = 32'h11111111; write_data1 = 32'h22222222;
    reg_write_en0 = 1'b1; reg_write_en1 = 1'b1;
    rs1 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("collide_bypass", read_data1, 32'h22222222);
`else
    chk("collide_pre", read_data1, 32'h0);
`endif
    edge_step();
    idle_writes();
    #1 chk("collide_r4", read_data1, 32'h22222222);

    // Bypass on register 5: old value 12345678, new A5A5A5A5.
    rd0 = 5'd5; write_data0 = 32'h12345678; reg_write_en0 = 1'b1;
    edge_step();
    rs1 = 5'd5; write_data0 = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r5", read_data1, 32'hA5A5A5A5);
`else
    chk("no_bypass_r5", read_data1, 32'h12345678);
`endif
    edge_step();
    idle_writes();
    #1 chk("after_edge_r5", read_data1, 32'hA5A5A5A5);

    // Directed fill: port 0 writes low registers, port 1 writes high ones, reads trail behind.
    for (int i = 1; i < 16; i++) begin
      rd0 = 5'(i);      write_data0 = 32'h01010101 * i;   reg_write_en0 = 1'b1;
      rd1 = 5'(31 - i); write_data1 = 32'hF0000000 | i;   reg_write_en1 = 1'b1;
      rs1 = 5'(i - 1);  rs2 = 5'(32 - i);
      edge_step();
    end
    idle_writes();
    rs1 = 5'd15; rs2 = 5'd16;
    #1 chk("fill_r15", read_data1, 32'h0F0F0F0F);
    chk("fill_r16", read_data2, 32'hF000000F);
    edge_step();
    edge_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
